// File: rtl/systolic_n_body_2x2_scheduler.sv
// systolic_n_body_2x2_scheduler
// Control sequencer for the 2x2 n-body systolic array and its Verlet
// integration stage. For each timestep it walks every (I,J) block pair,
// issues two feed beats per block, waits out the array latency, captures
// the array output, and fires integration once per completed block row.
//
// Optional feature macro: STALL_CNT_EN adds a 32-bit saturating count of
// FEED cycles spent stalled (output stall_cycles).
//
// Handshake: feed_valid is the only combinational output. It is high in
// FEED whenever stall is low, and a beat counts as accepted exactly in
// that cycle. While stall is high the beat counter and the addresses hold.
// Every other output is decoded from registered state and counters.
module systolic_n_body_2x2_scheduler #(
  parameter int MAX_BODIES = 64,
  parameter int IDX_W      = 6,
  parameter int ARRAY_LAT  = 2,
  parameter int STEP_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IDX_W:0]      n_bodies,
  input  logic [STEP_W-1:0]   n_steps,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    rd_addr_i,
  output logic [IDX_W-1:0]    rd_addr_j,
  output logic                feed_valid,
  output logic                feed_diag,
  output logic                acc_clear,
  output logic                acc_capture,
  output logic                integ_valid,
  output logic [IDX_W-2:0]    integ_addr,
  output logic [STEP_W-1:0]   step_count,
`ifdef STALL_CNT_EN
  output logic [31:0]         stall_cycles,
`endif
  output logic [2:0]          dbg_state
);

  localparam int HI_W  = IDX_W - 1;
  localparam int NB_W  = IDX_W + 1;
  localparam int LAT_W = (ARRAY_LAT < 2) ? 1 : $clog2(ARRAY_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_CAPT  = 3'd4,
    S_INTEG = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [HI_W-1:0]     blk_i;
  logic [HI_W-1:0]     blk_j;
  logic [HI_W-1:0]     nb_m1;
  logic                beat;
  logic [LAT_W-1:0]    wait_cnt;
  logic [STEP_W-1:0]   n_steps_q;
  logic [IDX_W-1:0]    nb_half;
  logic                start_legal;
  logic                last_i;
  logic                last_j;
  logic                last_step;

  assign nb_half     = n_bodies[IDX_W:1];
  assign start_legal = ~n_bodies[0]
                     && (n_bodies >= NB_W'(2))
                     && (n_bodies <= NB_W'(MAX_BODIES))
                     && (n_steps != '0);
  assign last_i      = (blk_i == nb_m1);
  assign last_j      = (blk_j == nb_m1);
  assign last_step   = ((step_count + STEP_W'(1)) == n_steps_q);
  assign dbg_state   = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt   = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    feed_valid  = 1'b0;
    feed_diag   = 1'b0;
    rd_addr_i   = '0;
    rd_addr_j   = '0;
    acc_clear   = 1'b0;
    acc_capture = 1'b0;
    integ_valid = 1'b0;
    integ_addr  = '0;
    case (state)
      S_IDLE: begin
        if (start && start_legal) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        feed_valid = ~stall;
        feed_diag  = (blk_i == blk_j);
        rd_addr_i  = {blk_i, beat};
        rd_addr_j  = {blk_j, beat};
        if (!stall && beat) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == LAT_W'(ARRAY_LAT - 1)) state_nxt = S_CAPT;
      end
      S_CAPT: begin
        acc_capture = 1'b1;
        state_nxt   = last_j ? S_INTEG : S_FEED;
      end
      S_INTEG: begin
        integ_valid = 1'b1;
        integ_addr  = blk_i;
        if (!last_i)        state_nxt = S_CLEAR;
        else if (last_step) state_nxt = S_DONE;
        else                state_nxt = S_CLEAR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Block indices, beat/latency counters, run configuration and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_i      <= '0;
      blk_j      <= '0;
      nb_m1      <= '0;
      beat       <= 1'b0;
      wait_cnt   <= '0;
      n_steps_q  <= '0;
      step_count <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_legal) begin
              err        <= 1'b0;
              step_count <= '0;
              blk_i      <= '0;
              blk_j      <= '0;
              beat       <= 1'b0;
              nb_m1      <= HI_W'(nb_half - IDX_W'(1));
              n_steps_q  <= n_steps;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          blk_j <= '0;
          beat  <= 1'b0;
        end
        S_FEED: begin
          wait_cnt <= '0;
          if (!stall) beat <= ~beat;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + LAT_W'(1);
        end
        S_CAPT: begin
          if (!last_j) blk_j <= blk_j + HI_W'(1);
        end
        S_INTEG: begin
          if (!last_i) begin
            blk_i <= blk_i + HI_W'(1);
          end else begin
            blk_i      <= '0;
            step_count <= step_count + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of stalled FEED cycles; restarts on each accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (state == S_IDLE) begin
      if (start && start_legal) stall_cycles <= '0;
    end else if (state == S_FEED && stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_n_body_2x2_scheduler.sv
// tb_systolic_n_body_2x2_scheduler
// Directed bench for the 2x2 n-body scheduler: reset, the four-body
// single-step schedule (plain, stalled, and with starts poked while busy),
// a three-step run, illegal starts, and reset in the middle of a run.
module tb_systolic_n_body_2x2_scheduler;

  localparam int IDX_W  = 6;
  localparam int STEP_W = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [IDX_W:0]    n_bodies;
  logic [STEP_W-1:0] n_steps;
  logic              stall;
  logic              busy, done, err;
  logic [IDX_W-1:0]  rd_addr_i, rd_addr_j;
  logic              feed_valid, feed_diag, acc_clear, acc_capture, integ_valid;
  logic [IDX_W-2:0]  integ_addr;
  logic [STEP_W-1:0] step_count;
  logic [2:0]        dbg_state;
`ifdef STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  systolic_n_body_2x2_scheduler #(
    .MAX_BODIES(64), .IDX_W(IDX_W), .ARRAY_LAT(2), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .n_bodies(n_bodies),
    .n_steps(n_steps), .stall(stall), .busy(busy), .done(done), .err(err),
    .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j), .feed_valid(feed_valid),
    .feed_diag(feed_diag), .acc_clear(acc_clear), .acc_capture(acc_capture),
    .integ_valid(integ_valid), .integ_addr(integ_addr),
    .step_count(step_count),
`ifdef STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pack of all schedule outputs: busy done clr cap integ fv diag ai aj ia
  function automatic logic [23:0] mk(input bit b, input bit d, input bit clr,
                                     input bit cap, input bit ig, input bit fv,
                                     input bit dg, input int ai, input int aj,
                                     input int ia);
    return {b, d, clr, cap, ig, fv, dg, 6'(ai), 6'(aj), 5'(ia)};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {busy, done, acc_clear, acc_capture, integ_valid, feed_valid,
            feed_diag, rd_addr_i, rd_addr_j, integ_addr};
  endfunction

  // Hand-written schedule for n_bodies=4, n_steps=1, ARRAY_LAT=2, no stall
  function automatic logic [23:0] base_vec(input int c);
    case (c)
      1:  return mk(1,0,1,0,0,0,0, 0,0,0);
      2:  return mk(1,0,0,0,0,1,1, 0,0,0);
      3:  return mk(1,0,0,0,0,1,1, 1,1,0);
      4, 5, 9, 10, 16, 17, 21, 22: return mk(1,0,0,0,0,0,0, 0,0,0);
      6, 11, 18, 23: return mk(1,0,0,1,0,0,0, 0,0,0);
      7:  return mk(1,0,0,0,0,1,0, 0,2,0);
      8:  return mk(1,0,0,0,0,1,0, 1,3,0);
      12: return mk(1,0,0,0,1,0,0, 0,0,0);
      13: return mk(1,0,1,0,0,0,0, 0,0,0);
      14: return mk(1,0,0,0,0,1,0, 2,0,0);
      15: return mk(1,0,0,0,0,1,0, 3,1,0);
      19: return mk(1,0,0,0,0,1,1, 2,2,0);
      20: return mk(1,0,0,0,0,1,1, 3,3,0);
      24: return mk(1,0,0,0,1,0,0, 0,0,1);
      25: return mk(1,1,0,0,0,0,0, 0,0,0);
      default: return '0;
    endcase
  endfunction

  // Stall on cycles 2-4: held in FEED beat 0 (diag, addresses 0), then +3
  function automatic logic [23:0] stall_vec(input int c);
    if (c < 2)  return base_vec(c);
    if (c <= 4) return mk(1,0,0,0,0,0,1, 0,0,0);
    return base_vec(c - 3);
  endfunction

  // Driver: one four-body single-step run, checked cycle by cycle
  task automatic run_n4(input bit with_stall, input bit poke_start, input string tag);
    @(posedge clk); #1;
    start = 1'b1; n_bodies = 7'd4; n_steps = 16'd1; stall = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, c), 32'(obs_vec()),
            32'(with_stall ? stall_vec(c) : base_vec(c)));
      if (c == 1) check({tag, "_err_clr"}, 32'(err), 32'd0);
      @(posedge clk); #1;
      start = poke_start && ((c + 1) == 5 || (c + 1) == 15 || (c + 1) == 25);
      stall = with_stall && ((c + 1) >= 2) && ((c + 1) <= 4);
    end
    check({tag, "_steps"}, 32'(step_count), 32'd1);
`ifdef STALL_CNT_EN
    check({tag, "_stall_cycles"}, stall_cycles, with_stall ? 32'd3 : 32'd0);
`endif
  endtask

  // Driver: one illegal start pulse, err must rise and busy stay low
  task automatic bad_start(input int nb, input int ns, input string tag);
    @(posedge clk); #1;
    start = 1'b1; n_bodies = 7'(nb); n_steps = 16'(ns);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; n_bodies = '0; n_steps = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    check("reset_err_steps", {15'd0, err, step_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_n4(1'b0, 1'b0, "plain");
    run_n4(1'b1, 1'b0, "stall");
    run_n4(1'b0, 1'b1, "poke");

    // Three timesteps: integ order and timing via the expected queue
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back({11'(24 * s + 12), 5'd0});
      exp_q.push_back({11'(24 * s + 24), 5'd1});
    end
    @(posedge clk); #1;
    start = 1'b1; n_bodies = 7'd4; n_steps = 16'd3;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (integ_valid) begin
        if (exp_q.size() == 0) check("multi_extra_integ", 32'(c), 32'hffff);
        else check("multi_integ", {16'd0, 11'(c), integ_addr}, 32'(exp_q.pop_front()));
      end
      if (c == 25) check("multi_step1", 32'(step_count), 32'd1);
      if (c == 49) check("multi_step2", 32'(step_count), 32'd2);
      if (c == 73) check("multi_step3", 32'(step_count), 32'd3);
      if (done || c == 73) check($sformatf("multi_done_c%0d", c), 32'(done), 32'(c == 73));
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("multi_integ_left", 32'(exp_q.size()), 32'd0);

    // Illegal starts, then a legal one clears err (checked inside run_n4)
    bad_start(3, 1, "bad_odd");
    bad_start(0, 1, "bad_zero");
    bad_start(66, 1, "bad_big");
    bad_start(4, 0, "bad_nsteps");
    run_n4(1'b0, 1'b0, "after_bad");

    // Reset in the middle of FEED of an eight-body run
    @(posedge clk); #1;
    start = 1'b1; n_bodies = 7'd8; n_steps = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_in_feed", 32'(feed_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fv", 32'(feed_valid), 32'd0);
    check("mid_rst_integ", 32'(integ_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_no_done", {30'd0, busy, done}, 32'd0);
      @(posedge clk); #1;
    end
    run_n4(1'b0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_n_body_2x2_scheduler.md
Name: systolic_n_body_2x2_scheduler

Overview:
- Control sequencer for the 2x2 n-body systolic cell array and its Verlet integration stage.
- Walks all (I,J) 2-body block pairs for N bodies and emits body-memory read addresses plus skewed feed strobes.
- Times array drain latency, tells the force accumulator when to clear and capture, and fires integration after each completed block row.
- Repeats for a programmed number of timesteps. Carries no real-valued data; control and indices only.

Parameters:
- MAX_BODIES, 64, largest legal body count (power of two, >=4).
- IDX_W, 6, body address width; must equal clog2(MAX_BODIES).
- ARRAY_LAT, 2, cycles from last feed beat of a block to valid array output (>=1).
- STEP_W, 16, timestep counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- n_bodies  in  IDX_W+1  body count; latched on accepted start.
- n_steps  in  STEP_W  timesteps to run; latched on accepted start.
- stall  in  1  body-memory backpressure; honoured only in FEED.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  set on rejected start.
- rd_addr_i  out  IDX_W  i-stream body address.
- rd_addr_j  out  IDX_W  j-stream body address.
- feed_valid  out  1  rd_addr_i/rd_addr_j valid this cycle.
- feed_diag  out  1  current block has I==J; array masks self-interaction.
- acc_clear  out  1  clear row force accumulators.
- acc_capture  out  1  array output valid; accumulate it.
- integ_valid  out  1  integrate row block integ_addr.
- integ_addr  out  IDX_W-1  row block index to integrate.
- step_count  out  STEP_W  completed timesteps in current run.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0; all counters 0. Reset mid-run abandons the run with no done.
- NB = n_bodies/2.
- Start legality: n_bodies even, 2<=n_bodies<=MAX_BODIES, n_steps!=0.
- IDLE:
  - Legal start -> CLEAR; clears err and step_count; I=J=0.
  - Illegal start -> err=1 (held until next accepted start); stay IDLE.
- CLEAR (1 cycle): acc_clear=1; J=0 -> FEED.
- FEED (2 beats, k=0,1):
  - rd_addr_i=2I+k, rd_addr_j=2J+k, feed_diag=(I==J).
  - feed_valid = FEED & ~stall (only combinational input->output path).
  - stall=1: beat counter frozen, addresses held, feed_valid=0.
  - After beat 1 accepted -> WAIT.
- WAIT (ARRAY_LAT cycles, stall ignored) -> CAPT.
- CAPT (1 cycle): acc_capture=1. J<NB-1: J++ -> FEED. Else -> INTEG.
- INTEG (1 cycle): integ_valid=1, integ_addr=I.
  - I<NB-1: I++ -> CLEAR.
  - Else step_count++; if new count == n_steps -> DONE, else I=0 -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE.
- Outputs other than feed_valid decode from registered state/counters.
- start while busy is ignored.
- Unstalled cycles per row = 2 + NB*(3+ARRAY_LAT).

Optional Feature:
- STALL_CNT_EN defined: adds output stall_cycles (32 bits) counting FEED cycles with stall=1. Cleared on accepted start and reset; saturates at all-ones; holds value in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- reset low mid-FEED in a n_bodies=8 run -> next cycle busy=0, feed_valid=0, integ_valid=0, no done; later start runs from I=J=0.
- n_bodies=4, n_steps=1, ARRAY_LAT=2, no stall, start at cycle 0:
  - acc_clear at 1 and 13.
  - feed beats at 2-3 (i 0,1 / j 0,1, diag=1), 7-8 (j 2,3, diag=0), 14-15 (i 2,3 / j 0,1), 19-20 (diag=1).
  - acc_capture at 6, 11, 18, 23; integ_valid at 12 (addr 0) and 24 (addr 1).
  - done at 25; busy high cycles 1-25.
- Same run with stall=1 on cycles 2-4 -> beat0 at 5, beat1 at 6, all later events +3 cycles, done at 28; with STALL_CNT_EN, stall_cycles=3.
- n_bodies=4, n_steps=3 -> six integ_valid pulses (addr 0,1,0,1,0,1); step_count 1,2,3 after cycles 24,48,72; done at 73.
- Illegal start (n_bodies=3, then 0, then 66, then n_steps=0) -> err=1, busy stays 0; next legal start clears err.
- start pulsed while busy -> ignored; schedule and done timing unchanged from the no-stall run.
